// File: rtl/ltsm_pkg.sv
// Shared LTSM definitions: MBTRAIN sideband message codes, sideband
// arbiter state encoding and requester source identifiers.
package ltsm_pkg;

  // MBTRAIN sideband message codes; 4'b0000 means "no response to send"
  localparam logic [3:0] MSG_NONE                     = 4'b0000;
  localparam logic [3:0] MSG_START_REQ                = 4'b0001;
  localparam logic [3:0] MSG_START_RESP               = 4'b0010;
  localparam logic [3:0] MSG_DONE_REQ                 = 4'b0011;
  localparam logic [3:0] MSG_DONE_RESP                = 4'b0100;
  localparam logic [3:0] MSG_EXIT_TO_REPAIR_REQ       = 4'b0101;
  localparam logic [3:0] MSG_EXIT_TO_REPAIR_RESP      = 4'b0110;
  localparam logic [3:0] MSG_EXIT_TO_SPEEDDEGRADE_REQ = 4'b0111;
  localparam logic [3:0] MSG_EXIT_TO_SPEEDDEGRADE_RESP= 4'b1000;
  localparam logic [3:0] MSG_MULTI_MODULE_DIS_REQ     = 4'b1001;
  localparam logic [3:0] MSG_MULTI_MODULE_DIS_RESP    = 4'b1010;
  localparam logic [3:0] MSG_EXIT_TO_PHYRETRAIN_REQ   = 4'b1011;
  localparam logic [3:0] MSG_EXIT_TO_PHYRETRAIN_RESP  = 4'b1100;

  // Requester identifiers as driven on o_sb_src
  localparam logic SRC_TX = 1'b0;
  localparam logic SRC_RX = 1'b1;

  // Sideband arbiter FSM states
  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    DONE,
    ERROR
  } arb_state_e;

endpackage

// File: rtl/sb_timeout_counter.sv
// Per-message timeout counter for the sideband busy window.
// expired flags the cycle on whose closing edge the count reaches
// TIMEOUT_CYCLES-1, so the owner can react on that same edge.
module sb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Terminal count is reached by the increment taken on this edge
  always_comb begin
    expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 2));
  end

endmodule

// File: rtl/mbtrain_sb_arbiter.sv
// Round-robin arbiter sharing the LTSM sideband transmit path between the
// TX-side and RX-side MBTRAIN sub-state FSMs, with busy-window tracking,
// per-requester completion pulses and a sticky per-message timeout.
module mbtrain_sb_arbiter
  import ltsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [3:0] i_tx_msg,
  input  logic       i_tx_valid,
  input  logic [3:0] i_rx_msg,
  input  logic       i_rx_valid,
  input  logic       i_sb_busy,
  output logic [3:0] o_sb_msg,
  output logic       o_sb_msg_valid,
  output logic       o_sb_src,
  output logic       o_tx_busy_negedge,
  output logic       o_rx_busy_negedge,
  output logic       o_timeout
);

  arb_state_e state;
  logic       served_tx;
  logic       served_rx;
  logic       last_grant;
  logic       elig_tx;
  logic       elig_rx;
  logic       grant_src;
  logic [3:0] grant_msg;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       expired;

  // Eligibility and round-robin pick; ties go to the requester not served last
  always_comb begin
    elig_tx   = i_tx_valid && !served_tx;
    elig_rx   = i_rx_valid && !served_rx;
    grant_src = SRC_TX;
    if (elig_tx && elig_rx) begin
      grant_src = ~last_grant;
    end else if (elig_rx) begin
      grant_src = SRC_RX;
    end
    grant_msg = (grant_src == SRC_RX) ? i_rx_msg : i_tx_msg;
  end

  // Timeout counter runs only while the busy window is being tracked
  always_comb begin
    cnt_clear  = !i_en || (state == LAUNCH);
    cnt_enable = (state == WAIT_HI) || (state == WAIT_LO);
  end

  sb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  // Arbiter FSM with registered outputs and served/round-robin bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      served_tx         <= 1'b0;
      served_rx         <= 1'b0;
      last_grant        <= SRC_RX;
      o_sb_msg          <= '0;
      o_sb_msg_valid    <= 1'b0;
      o_sb_src          <= SRC_TX;
      o_tx_busy_negedge <= 1'b0;
      o_rx_busy_negedge <= 1'b0;
      o_timeout         <= 1'b0;
    end else begin
      o_sb_msg_valid    <= 1'b0;
      o_tx_busy_negedge <= 1'b0;
      o_rx_busy_negedge <= 1'b0;
      // A served flag lasts only while its request level stays high
      if (!i_tx_valid) served_tx <= 1'b0;
      if (!i_rx_valid) served_rx <= 1'b0;

      if (!i_en) begin
        state     <= IDLE;
        served_tx <= 1'b0;
        served_rx <= 1'b0;
        o_timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARB;
          ARB: begin
            if (elig_tx || elig_rx) begin
              o_sb_msg <= grant_msg;
              o_sb_src <= grant_src;
              if (grant_msg == MSG_NONE) begin
                // Nothing to send: complete immediately without a launch
                state <= DONE;
                if (grant_src == SRC_RX) o_rx_busy_negedge <= 1'b1;
                else                     o_tx_busy_negedge <= 1'b1;
              end else begin
                state          <= LAUNCH;
                o_sb_msg_valid <= 1'b1;
              end
            end
          end
          LAUNCH: state <= WAIT_HI;
          WAIT_HI: begin
            if (expired) begin
              state     <= ERROR;
              o_timeout <= 1'b1;
            end else if (i_sb_busy) begin
              state <= WAIT_LO;
            end
          end
          WAIT_LO: begin
            if (expired) begin
              state     <= ERROR;
              o_timeout <= 1'b1;
            end else if (!i_sb_busy) begin
              state <= DONE;
              if (o_sb_src == SRC_RX) o_rx_busy_negedge <= 1'b1;
              else                    o_tx_busy_negedge <= 1'b1;
            end
          end
          DONE: begin
            state      <= ARB;
            last_grant <= o_sb_src;
            if (o_sb_src == SRC_RX) served_rx <= 1'b1;
            else                    served_tx <= 1'b1;
          end
          ERROR: state <= ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
